// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                               |
// | Description : Bundle of the fetch, data and memory-side signals of the     |
// |               single-port memory arbiter. 'slave' is the arbiter's view,   |
// |               'master' is the view of the CPU/memory environment.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // memory side
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rd;
  logic              m_wr;
  logic [DATA_W-1:0] m_rdata;
  // status
  logic              busy;
  logic              owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_rd, m_wr,
           busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_rd, m_wr,
           busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Single-port memory arbiter / access sequencer shared by the  |
// |               instruction fetch and data requesters of the multicycle CPU. |
// |               Each grant spends LAT cycles in ACCESS, then pulses the      |
// |               grantee's ack for one cycle.                                 |
// |               Macro ARB_ROUND_ROBIN_EN: when defined, a tie is granted to  |
// |               the requester not served last; otherwise data wins ties.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  wire          CLK,
  input  wire          RST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACCESS   = 2'd1;
  localparam logic [1:0] c_ACK      = 2'd2;
  localparam logic [3:0] c_CNT_LOAD = 4'(LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_req_any;
  logic              w_pick_d;
  logic              w_cnt_done;

  assign w_req_any  = bus.i_req | bus.d_req;
  assign w_cnt_done = (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  // on a tie, serve whoever was not the previous grantee
  assign w_pick_d = bus.d_req & (~bus.i_req | ~r_owner);
`else
  // data always wins a tie
  assign w_pick_d = bus.d_req;
`endif

  // state register, aborted to IDLE by reset at any time
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state: grant from IDLE, count out ACCESS, single ACK cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_req_any)  w_state_nxt = c_ACCESS;
      c_ACCESS: if (w_cnt_done) w_state_nxt = c_ACK;
      c_ACK:                    w_state_nxt = c_IDLE;
      default:                  w_state_nxt = c_IDLE;
    endcase
  end

  // grant latch, wait counter and read-data capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt     <= 4'd0;
      r_owner   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_pick_d;
            r_cnt   <= c_CNT_LOAD;
            if (w_pick_d) begin
              r_addr  <= bus.d_addr;
              r_wdata <= bus.d_wdata;
              r_we    <= bus.d_we;
            end else begin
              // fetches are always reads; write data is left as is
              r_addr  <= bus.i_addr;
              r_we    <= 1'b0;
            end
          end
        end
        c_ACCESS: begin
          if (w_cnt_done) begin
            if (!r_we) begin
              if (r_owner) r_d_rdata <= bus.m_rdata;
              else         r_i_rdata <= bus.m_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // strobes, acks and busy decoded from registered state only
  always_comb begin
    bus.m_rd  = 1'b0;
    bus.m_wr  = 1'b0;
    bus.i_ack = 1'b0;
    bus.d_ack = 1'b0;
    bus.busy  = (r_state != c_IDLE);
    if (r_state == c_ACCESS) begin
      bus.m_rd = ~r_we;
      bus.m_wr = r_we;
    end
    if (r_state == c_ACK) begin
      bus.i_ack = ~r_owner;
      bus.d_ack = r_owner;
    end
  end

  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.owner   = r_owner;

endmodule
`default_nettype wire
